uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Upstream stage of the UART RX: serializes a parallel byte into a UART frame on TX_OUT.
//  Frame: start(0), DATA_WIDTH data bits LSB-first, optional parity, stop(1).
//  Bit period is Prescale CLK cycles, so TX_OUT can drive RX_IN directly in loopback benches.
// PARAMETERS
//  DATA_WIDTH      8  payload bits per frame
//  PRESCALE_WIDTH  6  width of Prescale input and of the internal bit-period counter
// PORTS
//  CLK         in   1               system clock, rising edge
//  RST         in   1               asynchronous reset, active-low
//  P_DATA      in   DATA_WIDTH      byte to send, sampled on accept
//  DATA_VALID  in   1               request; accepted when high and busy==0
//  PAR_EN      in   1               1: parity bit inserted after data
//  PAR_TYP     in   1               0: even, 1: odd
//  Prescale    in   PRESCALE_WIDTH  CLK cycles per bit; 0 treated as 1
//  TX_OUT      out  1               serial line, idle high, registered
//  busy        out  1               frame in progress, registered
// BEHAVIOUR
//  - Reset (async, RST==0): state IDLE, TX_OUT=1, busy=0, counters=0; asserting reset mid-frame aborts the frame immediately.
//  - Accept: rising edge with state==IDLE && DATA_VALID==1.
//    - P_DATA, PAR_EN, PAR_TYP and Prescale are latched at accept.
//    - Input changes during a frame have no effect.
//  - On the accepting edge: state->START, TX_OUT=0, busy=1. Latency request->start bit is 0 extra cycles.
//  - FSM IDLE->START->DATA->(PARITY if PAR_EN)->STOP->IDLE. Each state holds TX_OUT for exactly Prescale cycles.
//    - DATA repeats for DATA_WIDTH bits, index 0 first.
//  - Parity bit = ^data for even, ~^data for odd, computed from the latched byte.
//  - busy high for exactly (DATA_WIDTH+2+PAR_EN)*Prescale cycles.
//  - STOP->IDLE edge: TX_OUT=1, busy=0. A back-to-back request is accepted on the following edge.
//    - The minimum line idle between frames is one CLK cycle of 1 beyond the stop bit.
//  - DATA_VALID while busy==1 is ignored; the requester holds it until busy==0.
//  - Bit counter 0..Prescale-1 wraps at the terminal count; the state advances on terminal count only.
//  - Data index counter is $clog2(DATA_WIDTH) bits wide, with no wrap beyond DATA_WIDTH-1.
// CONFIGURATION
//  UART_TX_STOP2_EN defined:
//    - STOP lasts 2*Prescale cycles (two stop bits).
//    - busy length becomes (DATA_WIDTH+3+PAR_EN)*Prescale.
//  UART_TX_STOP2_EN undefined: one stop bit, as above.
// STRUCTURE
//  - Package uart_pkg holds:
//    - typedef enum logic[2:0] {IDLE,START,DATA,PARITY,STOP} uart_tx_state_e
//    - PAR_EVEN=1'b0, PAR_ODD=1'b1
//    - default DATA_WIDTH and PRESCALE_WIDTH constants
//  - Sub-module uart_bit_timer: Prescale-period counter with an enable and a terminal-count pulse.
//    - It is shared later with the RX sampler.
//  - The top holds the FSM, shift register, parity and output registers.
// TESTING
//  1. Reset: RST=0 for 3 cycles mid-frame -> TX_OUT=1, busy=0 asynchronously; a new frame starts normally after release.
//  2. P_DATA=8'hCE, PAR_EN=1, PAR_TYP=0, Prescale=8:
//     - TX_OUT: 0, 0,1,1,1,0,0,1,1, 1(parity), 1(stop), each 8 cycles.
//     - busy high for 88 cycles.
//  3. P_DATA=8'hD1, PAR_EN=1, PAR_TYP=1, Prescale=16 -> parity bit 1, 176 busy cycles.
//     - Looped into the UART RX, it yields P_DATA 8'hD1 with data_valid.
//  4. PAR_EN=0, P_DATA=8'h00, Prescale=1 -> 10-cycle frame (0 x9, then 1); busy high 10 cycles.
//  5. Back-to-back: DATA_VALID held high with 8'hCE then 8'hD1, Prescale=8:
//     - the second start bit begins exactly 1 cycle after the first stop bit ends;
//     - DATA_VALID during busy is not double-accepted.
//  6. Change Prescale, PAR_EN and P_DATA mid-frame -> the current frame is unchanged.
//     - With UART_TX_STOP2_EN defined, case 2 busy=96 cycles, 16 stop cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity encodings and default widths
package uart_pkg;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int PRESCALE_WIDTH_DEF = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  // Parity bit for a payload whose XOR-reduction is data_xor.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with enable and terminal-count pulse
module uart_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [PRESCALE_WIDTH-1:0] period_i,
  output logic                      tc_o
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  // period_i is at least 1; the caller maps a zero prescale to 1.
  assign tc_o = en_i && (cnt_q == (period_i - 1'b1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tc_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer; UART_TX_STOP2_EN selects two stop bits
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  uart_tx_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bit_tc;
`ifdef UART_TX_STOP2_EN
  logic                      stop2_q, stop2_d;
`endif

  uart_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .en_i     (state_q != IDLE),
    .period_i (presc_q),
    .tc_o     (bit_tc)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    presc_d   = presc_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_STOP2_EN
    stop2_d   = stop2_q;
`endif
    // tx_d is the level of the state being entered, so TX_OUT stays registered.
    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_d   = START;
          shift_d   = P_DATA;
          idx_d     = '0;
          par_en_d  = PAR_EN;
          par_bit_d = parity_bit(^P_DATA, PAR_TYP);
          presc_d   = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_tc) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tc) begin
          if (idx_q == IDX_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_tc) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_tc) begin
`ifdef UART_TX_STOP2_EN
          if (!stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            stop2_d = 1'b0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      presc_q   <= PRESCALE_WIDTH'(1);
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      presc_q   <= presc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int nstop;

  always #5 CLK = ~CLK;

  uart_tx_serializer dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  // Expected line waveform built from the frame definition, one entry per clock.
  // Caller must be just after a falling edge; returns just after a falling edge.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] p, input bit hold, input bit mutate,
                           input string tag);
    int   peff;
    int   ones;
    logic bits[$];
    logic exp_tx[$];
    peff = (p == 0) ? 1 : int'(p);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) bits.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    for (int s = 0; s < nstop; s++) bits.push_back(1'b1);
    foreach (bits[b]) for (int r = 0; r < peff; r++) exp_tx.push_back(bits[b]);

    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = p; DATA_VALID = 1'b1;
    @(posedge CLK);
    for (int k = 0; k < exp_tx.size(); k++) begin
      @(negedge CLK);
      if (!hold) DATA_VALID = 1'b0;
      checks++;
      if (TX_OUT !== exp_tx[k] || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b, expected tx=%b busy=1",
                 tag, k, TX_OUT, busy, exp_tx[k]);
      end
      if (mutate && k == 2) begin
        P_DATA   = 8'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        Prescale = 6'($urandom_range(0, 63));
      end
    end
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle gap: tx=%b busy=%b, expected tx=1 busy=0", tag, TX_OUT, busy);
    end
  endtask

  task automatic check_idle(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s idle %0d: tx=%b busy=%b, expected tx=1 busy=0", tag, c, TX_OUT, busy);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4;
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    check_idle(2, "post_reset");
    DATA_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (8) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_midframe_pre: tx=%b busy=%b, expected tx=0 busy=1", TX_OUT, busy);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, busy);
    end
    check_idle(3, "reset_hold");
    RST = 1'b1;
    check_idle(2, "reset_release");
    run_frame(8'hA5, 1'b1, 1'b0, 6'd3, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_even_parity();
    run_frame(8'hCE, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, "even_ce_p8");
  endtask

  task automatic test_odd_parity();
    run_frame(8'hD1, 1'b1, 1'b1, 6'd16, 1'b0, 1'b0, "odd_d1_p16");
  endtask

  task automatic test_no_parity_min_prescale();
    run_frame(8'h00, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0, "nopar_00_p1");
    run_frame(8'h3C, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, "nopar_3c_p0");
  endtask

  task automatic test_back_to_back();
    run_frame(8'hCE, 1'b1, 1'b0, 6'd8, 1'b1, 1'b0, "b2b_first");
    run_frame(8'hD1, 1'b1, 1'b1, 6'd8, 1'b0, 1'b0, "b2b_second");
    check_idle(4, "b2b_after");
  endtask

  task automatic test_midframe_change();
    run_frame(8'h5A, 1'b1, 1'b1, 6'd5, 1'b0, 1'b1, "midframe_change");
    check_idle(3, "midframe_after");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [7:0] d;
      logic       pe, pt;
      logic [5:0] p;
      bit         hold, mut;
      d    = 8'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      p    = 6'($urandom_range(0, 6));
      hold = 1'($urandom);
      mut  = hold ? 1'b0 : 1'($urandom);
      run_frame(d, pe, pt, p, hold, mut, $sformatf("random_%0d", n));
    end
    DATA_VALID = 1'b0;
    check_idle(3, "random_after");
  endtask

  initial begin
`ifdef UART_TX_STOP2_EN
    nstop = 2;
`else
    nstop = 1;
`endif
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity_min_prescale();
    test_back_to_back();
    test_midframe_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
